// File: rtl/feeder_pkg.sv
// Shared definitions for the operand feeder: default sizes and FSM encoding.
package feeder_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int DEPTH_DEF  = 8;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for an already-synchronised level.
// The history register resets to 1, so a level that is held high
// through reset does not produce a spurious edge afterwards.
module rise_detect (
  input  logic clock,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic level_q;

  // Remember last cycle's level; reset high to suppress edges from held inputs.
  always_ff @(posedge clock) begin
    if (reset) level_q <= 1'b1;
    else       level_q <= level;
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/operand_feeder.sv
// Operand feeder: collects operands strobed in from the switches into a small
// buffer, then streams them one per handshake to the datapath. From DONE the
// same sequence can be replayed, or a new sequence started.
module operand_feeder
  import feeder_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enter,
  input  logic [DATA_W-1:0] data_in,
  input  logic              go,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  count,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam int PTR_W = $clog2(DEPTH);

  state_t            state, next_state;
  logic [DATA_W-1:0] op_buf [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, next_wr_ptr, next_rd_ptr, wr_addr;
  logic [CNT_W-1:0]  next_count;
  logic              next_overflow, wr_en;
  logic              enter_rise, go_rise, full, last;

  rise_detect u_enter_rise (
    .clock (clock),
    .reset (reset),
    .level (enter),
    .rise  (enter_rise)
  );

  rise_detect u_go_rise (
    .clock (clock),
    .reset (reset),
    .level (go),
    .rise  (go_rise)
  );

  assign full     = (count == CNT_W'(DEPTH));
  assign last     = (CNT_W'(rd_ptr) == count - CNT_W'(1));
  assign out_data = op_buf[rd_ptr];

  // Next-state, pointer/count updates and state-decoded outputs.
  always_comb begin
    next_state    = state;
    next_wr_ptr   = wr_ptr;
    next_rd_ptr   = rd_ptr;
    next_count    = count;
    next_overflow = overflow;
    wr_en         = 1'b0;
    wr_addr       = wr_ptr;
    out_valid     = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    case (state)
      LOAD: begin
        if (enter_rise) begin
          if (!full) begin
            wr_en       = 1'b1;
            next_wr_ptr = wr_ptr + PTR_W'(1);
            next_count  = count + CNT_W'(1);
          end else begin
            next_overflow = 1'b1;
          end
        end
        // The go decision sees the count including a same-cycle write.
        if (go_rise && next_count != '0) begin
          next_state  = STREAM;
          next_rd_ptr = '0;
        end
      end
      STREAM: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) begin
          next_rd_ptr = rd_ptr + PTR_W'(1);
          if (last) next_state = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (enter_rise) begin
          next_state    = LOAD;
          wr_en         = 1'b1;
          wr_addr       = '0;
          next_wr_ptr   = PTR_W'(1);
          next_count    = CNT_W'(1);
          next_overflow = 1'b0;
        end else if (go_rise) begin
          next_state  = STREAM;
          next_rd_ptr = '0;
        end
      end
      default: next_state = LOAD;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= LOAD;
    else       state <= next_state;
  end

  // Pointer, count and sticky overflow registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      wr_ptr   <= next_wr_ptr;
      rd_ptr   <= next_rd_ptr;
      count    <= next_count;
      overflow <= next_overflow;
    end
  end

  // Operand storage; contents survive reset, only the pointers are cleared.
  always_ff @(posedge clock) begin
    if (wr_en) op_buf[wr_addr] <= data_in;
  end

endmodule

// File: tb/tb_operand_feeder.sv
// Scoreboard bench for operand_feeder: stimulus pushes expected operands,
// a monitor pops and compares on every accepted transfer.
module tb_operand_feeder;

  logic       clock = 1'b0;
  logic       reset;
  logic       enter;
  logic [3:0] data_in;
  logic       go;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] count;
  logic       busy;
  logic       done;
  logic       overflow;

  int checks   = 0;
  int failures = 0;
  logic [3:0] exp_q [$];

  operand_feeder dut (
    .clock     (clock),
    .reset     (reset),
    .enter     (enter),
    .data_in   (data_in),
    .go        (go),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow)
  );

  // Free-running clock.
  always #5 clock = ~clock;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Monitor: compare every accepted transfer against the scoreboard.
  always @(negedge clock) begin
    if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_transfer: got %0h expected none", out_data);
      end else begin
        check_output("stream_data", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; enter = 1'b0; go = 1'b0; out_ready = 1'b0; data_in = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic apply_stimulus(input logic [3:0] v);
    data_in = v; enter = 1'b1;
    tick();
    enter = 1'b0;
    tick();
  endtask

  task automatic press_go();
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic wait_done(input string name, input int expected_cycles);
    int n = 0;
    while (done !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check_output(name, 32'(n), 32'(expected_cycles));
  endtask

  initial begin
    // Reset with enter held high: no edge after release.
    reset = 1'b1; enter = 1'b1; go = 1'b0; out_ready = 1'b0; data_in = 4'h6;
    tick(); tick();
    reset = 1'b0;
    tick();
    check_output("reset_count", 32'(count), 0);
    check_output("reset_valid", 32'(out_valid), 0);
    check_output("reset_done", 32'(done), 0);
    check_output("reset_busy", 32'(busy), 0);
    check_output("reset_overflow", 32'(overflow), 0);
    enter = 1'b0;
    tick();
    check_output("held_enter_count", 32'(count), 0);

    // Basic sequence 3,7,A with out_ready always high.
    do_reset();
    apply_stimulus(4'h3); apply_stimulus(4'h7); apply_stimulus(4'hA);
    check_output("load3_count", 32'(count), 3);
    out_ready = 1'b1;
    exp_q.push_back(4'h3); exp_q.push_back(4'h7); exp_q.push_back(4'hA);
    press_go();
    check_output("go_latency_valid", 32'(out_valid), 1);
    check_output("go_latency_busy", 32'(busy), 1);
    wait_done("basic_cycles", 3);
    check_output("basic_valid_after", 32'(out_valid), 0);
    check_output("basic_count_after", 32'(count), 3);
    check_output("basic_drain", 32'(exp_q.size()), 0);

    // Replay from DONE.
    exp_q.push_back(4'h3); exp_q.push_back(4'h7); exp_q.push_back(4'hA);
    tick();
    press_go();
    check_output("replay_valid", 32'(out_valid), 1);
    wait_done("replay_cycles", 3);
    check_output("replay_drain", 32'(exp_q.size()), 0);

    // New sequence from DONE with enter.
    out_ready = 1'b0;
    apply_stimulus(4'hC);
    check_output("restart_done", 32'(done), 0);
    check_output("restart_valid", 32'(out_valid), 0);
    check_output("restart_count", 32'(count), 1);
    check_output("restart_overflow", 32'(overflow), 0);

    // Stall: data held while out_ready low.
    do_reset();
    apply_stimulus(4'h5); apply_stimulus(4'h9);
    exp_q.push_back(4'h5); exp_q.push_back(4'h9);
    press_go();
    for (int i = 0; i < 4; i++) begin
      check_output("stall_data_5", 32'(out_data), 5);
      check_output("stall_valid_5", 32'(out_valid), 1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_output("stall_data_9", 32'(out_data), 9);
    tick();
    check_output("stall_hold_9", 32'(out_data), 9);
    out_ready = 1'b1;
    wait_done("stall_cycles", 1);
    check_output("stall_drain", 32'(exp_q.size()), 0);

    // Overflow: nine enters into an eight-deep buffer.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      apply_stimulus(4'(i));
      if (i < 8) exp_q.push_back(4'(i));
    end
    check_output("full_count", 32'(count), 8);
    check_output("full_overflow", 32'(overflow), 1);
    out_ready = 1'b1;
    press_go();
    wait_done("full_cycles", 8);
    check_output("full_drain", 32'(exp_q.size()), 0);
    check_output("full_overflow_kept", 32'(overflow), 1);

    // go with an empty buffer is ignored.
    do_reset();
    press_go();
    tick();
    check_output("empty_go_valid", 32'(out_valid), 0);
    check_output("empty_go_done", 32'(done), 0);

    // Same-cycle enter and go from empty streams the single operand.
    data_in = 4'h4; enter = 1'b1; go = 1'b1;
    exp_q.push_back(4'h4);
    tick();
    enter = 1'b0; go = 1'b0;
    check_output("same_cycle_valid", 32'(out_valid), 1);
    check_output("same_cycle_count", 32'(count), 1);
    out_ready = 1'b1;
    wait_done("same_cycle_cycles", 1);
    check_output("same_cycle_drain", 32'(exp_q.size()), 0);

    // Reset mid-stream drops the sequence.
    do_reset();
    apply_stimulus(4'h1); apply_stimulus(4'h2); apply_stimulus(4'h3);
    press_go();
    check_output("mid_valid_before", 32'(out_valid), 1);
    reset = 1'b1;
    tick();
    check_output("mid_reset_valid", 32'(out_valid), 0);
    check_output("mid_reset_count", 32'(count), 0);
    reset = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/operand_feeder.md
Name: operand_feeder

Overview:
Input-side companion to the bc/bo datapath. The feeder captures a sequence of 4-bit operands that the user enters on the board switches, strobing each one with a push-button. It buffers them, then streams them one per handshake into the operator block. This is the writer end of the operand interface that the datapath consumes; the existing top-level drives the HEX displays on the reader end.

Parameters:
DATA_W, 4, operand width in bits (SW[3:0])
DEPTH, 8, operand buffer capacity; must be a power of 2, ≥2
CNT_W, 4, count width; must equal clog2(DEPTH)+1

Ports:
clock  input  1  system clock; rising edge active
reset  input  1  synchronous, active-high reset
enter  input  1  operand strobe level (button already inverted to active-high and synchronised)
data_in  input  DATA_W  operand value from switches
go  input  1  start-streaming level (switch)
out_data  output  DATA_W  operand presented to the datapath
out_valid  output  1  out_data is valid
out_ready  input  1  datapath accepts out_data this cycle
count  output  CNT_W  number of operands currently buffered
busy  output  1  high while in STREAM
done  output  1  high in DONE
overflow  output  1  sticky: an enter edge was rejected because the buffer was full

Behaviour:
- Edge detection: enter_rise = enter & ~enter_q; go_rise = go & ~go_q.
  - enter_q and go_q are registered every cycle.
  - reset sets both to 1, so a level already held high through reset produces no edge.
- Reset values: state=LOAD, count=0, wr_ptr=0, rd_ptr=0, out_valid=0, busy=0, done=0, overflow=0. out_data is don't-care while out_valid=0. Buffer contents are not cleared.
- Reset mid-STREAM drops the sequence immediately; out_valid=0 the next cycle.
- FSM states: LOAD, STREAM, DONE. Encoding comes from the shared package.
- LOAD:
  - enter_rise with count<DEPTH writes data_in to buf[wr_ptr]; wr_ptr++ and count++ take effect the next cycle.
  - enter_rise with count==DEPTH: no write, overflow<=1.
  - go_rise with count>0: STREAM, rd_ptr<=0.
  - go_rise with count==0 is ignored.
  - enter_rise and go_rise in the same cycle: the write happens first and the go decision uses count+1. So a first-operand-plus-go cycle still enters STREAM, and the new operand is included.
- STREAM:
  - out_valid=1 (combinational from state); out_data=buf[rd_ptr]; busy=1.
  - Latency: go_rise sampled at edge n gives out_valid=1 during cycle n+1.
  - Handshake: a transfer occurs on any cycle where out_valid & out_ready, and rd_ptr++ follows.
  - out_data is held stable while out_valid=1 and out_ready=0, for any stall length.
  - Transfer with rd_ptr==count-1: DONE next cycle; out_valid drops the same next cycle.
  - enter and go edges are ignored; overflow is unchanged.
- DONE:
  - done=1, out_valid=0; count retains its value, so the display can show the total sent.
  - go_rise replays the same sequence: STREAM, rd_ptr<=0.
  - enter_rise starts a new sequence: LOAD, buf[0]<=data_in, wr_ptr<=1, count<=1, overflow<=0.
  - If both edges arrive in the same cycle, enter_rise wins.
- Width rules:
  - wr_ptr/rd_ptr are clog2(DEPTH) bits; no wrap occurs because count saturates at DEPTH.
  - count reaches exactly DEPTH, so it needs CNT_W bits.
- out_ready is ignored outside STREAM.

Decomposition:
- Shared package feeder_pkg:
  - state typedef {LOAD, STREAM, DONE}
  - DATA_W and DEPTH defaults
- One natural sub-module: rise_detect (registered level plus reset-to-1, output rise pulse). It is instantiated twice, for enter and go.
- The buffer is an inline register array; no separate RAM module.

Test Plan:
- Reset with enter held high, then release → count=0, no write, state LOAD.
- Enter 3,7,A with edges, go_rise, out_ready=1 constantly → out_data 3,7,A on three consecutive cycles starting 1 cycle after go; then done=1, out_valid=0, count=3.
- Load 2 operands (5,9); out_ready low for 4 cycles, then pulse it → out_data stays 5 for all stall cycles; 9 follows after the accept; no duplicates, no drops.
- 9 enter edges with DEPTH=8 (values 0..8) → count=8, overflow=1, streamed values 0..7 only.
- go_rise with count=0 → stays LOAD, out_valid=0. Same-cycle enter(4)+go from empty → STREAM with single operand 4.
- In DONE: go_rise replays 3,7,A. Then in DONE, enter_rise with data_in=C → LOAD, count=1, overflow=0. Reset asserted mid-STREAM → out_valid=0 next cycle, count=0.
